// File: rtl/mpx_rr_arbiter_pkg.sv
// Shared constants for the 4-input round-robin MPX arbiter: FSM encodings,
// requester count, default grant timeout and a one-hot to index helper.
package mpx_rr_arbiter_pkg;

  localparam int NUM_REQ            = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/mpx_rr_pick.sv
// Rotate-priority encoder: grants the first set req bit searching upward
// (mod 4) from last+1.
module mpx_rr_pick
  import mpx_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  always_comb begin
    logic [1:0] idx;
    grant = '0;
    valid = 1'b0;
    idx   = 2'd0;
    // k = 4 wraps to last itself, so the previous winner has lowest priority
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last + k[1:0];
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpx_rr_arbiter.sv
// Round-robin arbiter driving the one-hot select of a 4:1 MPX (IDLE/XFER/GAP).
// Optional grant timeout enabled by defining MPX_ARB_TIMEOUT_EN.
module mpx_rr_arbiter
  import mpx_rr_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] sel,
  output logic               out_valid,
  output logic [NUM_REQ-1:0] done,
  output logic               busy,
  output logic               timeout_err,
  output logic [1:0]         dbg_state
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mpx_rr_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]         state;
  logic [1:0]         last;
  logic [1:0]         cur;
  logic               armed;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_valid;

`ifdef MPX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`endif

  assign dbg_state = state;

  mpx_rr_pick u_pick (
    .req   (req),
    .last  (last),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // armed delays the first grant after reset release by one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sel         <= '0;
      out_valid   <= 1'b0;
      done        <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      last        <= 2'd3;
      cur         <= 2'd0;
      armed       <= 1'b0;
`ifdef MPX_ARB_TIMEOUT_EN
      tcnt        <= '0;
`endif
    end else begin
      armed       <= 1'b1;
      done        <= '0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (armed && pick_valid) begin
            sel       <= pick_grant;
            out_valid <= 1'b1;
            cur       <= onehot_to_idx(pick_grant);
            busy      <= 1'b1;
            state     <= ST_XFER;
`ifdef MPX_ARB_TIMEOUT_EN
            tcnt      <= '0;
`endif
          end
        end
        ST_XFER: begin
          if (out_ready) begin
            done      <= sel;
            last      <= cur;
            sel       <= '0;
            out_valid <= 1'b0;
            state     <= ST_GAP;
          end
`ifdef MPX_ARB_TIMEOUT_EN
          // revoke on the edge where the wait count reaches TIMEOUT_CYCLES
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            last        <= cur;
            sel         <= '0;
            out_valid   <= 1'b0;
            state       <= ST_GAP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        ST_GAP: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          sel       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mpx_rr_arbiter.md
MPX_RR_ARBITER -- requirements
Module: mpx_rr_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, number of cycles a grant may wait for out_ready before it is revoked (used only with MPX_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-requester transfer request; bit i = requester i (drives MPX input Ii).
REQ-005 out_ready  input  1  consumer of the MPX output accepts the current word.
REQ-006 sel  output  4  one-hot select to the 4:1 16-bit MPX; 4'b0000 when no grant.
REQ-007 out_valid  output  1  MPX output holds a granted word.
REQ-008 done  output  4  one-cycle pulse on bit i when requester i's word is accepted.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.
REQ-010 timeout_err  output  1  one-cycle pulse on grant revocation; tied 0 without MPX_ARB_TIMEOUT_EN.

Function
REQ-011 FSM states: IDLE, XFER, GAP; all outputs registered.
REQ-012 IDLE: if req != 0, the arbiter SHALL grant the first set bit searching upward (mod 4) from last+1, load sel one-hot, and go to XFER; otherwise remain in IDLE.
REQ-013 Latency: req sampled high in IDLE -> sel/out_valid high on the next cycle.
REQ-014 XFER: sel stable, out_valid=1; on out_ready=1 the arbiter SHALL pulse done[i] for one cycle, set last=i, clear sel/out_valid, and go to GAP.
REQ-015 GAP: one bubble cycle, outputs idle, then IDLE; peak throughput is one word per 3 cycles.
REQ-016 req[i] dropping during XFER SHALL NOT abort the grant; the transfer completes on out_ready.
REQ-017 Simultaneous requests: exactly one bit granted; a requester held high SHALL wait at most 3 other grants.
REQ-018 sel SHALL never have more than one bit set; sel != 0 iff out_valid=1.
REQ-019 req changes while in XFER or GAP SHALL be ignored until IDLE.

Reset
REQ-020 rst_n low SHALL immediately force: state=IDLE, sel=0, out_valid=0, done=0, busy=0, timeout_err=0, last=3 (requester 0 has first priority), timeout counter=0.
REQ-021 Reset asserted mid-XFER SHALL drop the grant with no done pulse.
REQ-022 First grant after reset release SHALL occur no earlier than the second rising edge.

Configuration
REQ-023 Macro MPX_ARB_TIMEOUT_EN defined: a counter SHALL increment in each XFER cycle with out_ready=0; when it reaches TIMEOUT_CYCLES the arbiter SHALL clear sel/out_valid, pulse timeout_err, set last=i, no done, and go to GAP.
REQ-024 Macro not defined: no counter is implemented, XFER waits indefinitely, timeout_err is constant 0.

Structure
REQ-025 Shared package/include: state encodings (IDLE, XFER, GAP), NUM_REQ=4, default TIMEOUT_CYCLES.
REQ-026 One sub-module: mpx_rr_pick (combinational rotate-priority encoder: req[3:0], last[1:0] -> one-hot grant, valid).
REQ-027 Top-level integration SHALL connect sel directly to MPX s; the arbiter carries no 16-bit data.

Verification
REQ-028 Single request: req=4'b0100, out_ready=1 -> sel=4'b0100 one cycle after sampling, done=4'b0100 pulse, then 1 GAP cycle.
REQ-029 All requesting: req=4'b1111 held, out_ready=1 -> grant order 0001, 0010, 0100, 1000, 0001, one word per 3 cycles.
REQ-030 Backpressure: req=4'b0010, out_ready=0 for 5 cycles then 1 -> sel=4'b0010 stable all 6 cycles, done pulses once.
REQ-031 Fairness after skip: last=1, req=4'b1001 -> grant 4'b1000 before 4'b0001.
REQ-032 Reset mid-XFER: rst_n low during sel=4'b0001 -> sel=0, out_valid=0 within same cycle, no done; after release req=4'b0011 grants 4'b0001 first.
REQ-033 With MPX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4: req=4'b0001, out_ready=0 -> timeout_err pulses after 4 XFER cycles, sel=0, done=0; with req=4'b0011 held, next grant 4'b0010.
